// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/flush sequencer.
// Holds the FSM state encoding and the down-counter width helper.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

    // Down-counter holds at most max(FLUSH_CYC, LU_CYC) - 2.
    function automatic int dc_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Ports: clk, rst_n (async low), inc, clr, cnt[W-1:0].
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 4-stage pipeline.
// In: stage 2 sources, stage 3 load/wb/branch, stage 4 busy, counter clear.
// Out: per-stage stall, s3 bubble, s1/s2 flush, PC redirect, debug state,
//      saturating stall-cycle and branch counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_BITS  = 4,
    parameter int FLUSH_CYC = 2,
    parameter int LU_CYC    = 1,
    parameter int CNT_W     = 16
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [REG_BITS-1:0] s2_rs_a_i,
    input  logic                s2_rs_a_used_i,
    input  logic [REG_BITS-1:0] s2_rs_b_i,
    input  logic                s2_rs_b_used_i,
    input  logic                s3_load_i,
    input  logic                s3_do_wb_i,
    input  logic [REG_BITS-1:0] s3_wb_reg_i,
    input  logic                s3_take_branch_i,
    input  logic                s4_mem_busy_i,
    input  logic                clr_cnt_i,
    output logic                stall_s1_o,
    output logic                stall_s2_o,
    output logic                stall_s3_o,
    output logic                bubble_s3_o,
    output logic                flush_s1_o,
    output logic                flush_s2_o,
    output logic                redirect_o,
    output logic [1:0]          state_o,
    output logic [CNT_W-1:0]    stall_cnt_o,
    output logic [CNT_W-1:0]    branch_cnt_o
);

    localparam int DC_W = dc_width(FLUSH_CYC, LU_CYC);

    localparam logic [DC_W-1:0] FLUSH_LOAD =
        DC_W'((FLUSH_CYC > 1) ? FLUSH_CYC - 2 : 0);
    localparam logic [DC_W-1:0] LU_LOAD =
        DC_W'((LU_CYC > 1) ? LU_CYC - 2 : 0);

    logic [1:0]      state_q, state_d;
    logic [DC_W-1:0] cnt_q, cnt_d;
    logic            hazard;

    assign hazard = s3_load_i & s3_do_wb_i &
                    ((s2_rs_a_used_i & (s2_rs_a_i == s3_wb_reg_i)) |
                     (s2_rs_b_used_i & (s2_rs_b_i == s3_wb_reg_i)));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        stall_s1_o  = 1'b0;
        stall_s2_o  = 1'b0;
        stall_s3_o  = 1'b0;
        bubble_s3_o = 1'b0;
        flush_s1_o  = 1'b0;
        flush_s2_o  = 1'b0;
        redirect_o  = 1'b0;
        // Encoding 3 is unreachable; fall back to RUN even while frozen.
        state_d     = (state_q == 2'd3) ? ST_RUN : state_q;
        cnt_d       = cnt_q;
        // Outputs are combinational, so gate them while reset is held.
        if (!rst_n_i) begin
            state_d = ST_RUN;
        end else if (s4_mem_busy_i) begin
            stall_s1_o = 1'b1;
            stall_s2_o = 1'b1;
            stall_s3_o = 1'b1;
        end else begin
            case (state_q)
                ST_LU_STALL: begin
                    stall_s1_o  = 1'b1;
                    stall_s2_o  = 1'b1;
                    bubble_s3_o = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_FLUSH: begin
                    // Stage 3 holds killed ops here: branch/hazard ignored.
                    flush_s1_o = 1'b1;
                    flush_s2_o = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    if (s3_take_branch_i) begin
                        redirect_o = 1'b1;
                        flush_s1_o = 1'b1;
                        flush_s2_o = 1'b1;
                        if (FLUSH_CYC > 1) begin
                            state_d = ST_FLUSH;
                            cnt_d   = FLUSH_LOAD;
                        end
                    end else if (hazard) begin
                        stall_s1_o  = 1'b1;
                        stall_s2_o  = 1'b1;
                        bubble_s3_o = 1'b1;
                        if (LU_CYC > 1) begin
                            state_d = ST_LU_STALL;
                            cnt_d   = LU_LOAD;
                        end
                    end
                end
            endcase
        end
    end

    assign state_o = state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .inc   (stall_s1_o),
        .clr   (clr_cnt_i),
        .cnt   (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .inc   (redirect_o),
        .clr   (clr_cnt_i),
        .cnt   (branch_cnt_o)
    );

endmodule
